// File: rtl/perf_event_counter_bank.sv
// perf_event_counter_bank
// Two-channel performance event counter bank. Each channel counts the
// registered event strobe picked by its select input. A select change clears
// the channel's count and its sticky overflow flag.
// Optional feature: define PERF_OVERFLOW_IRQ_EN to add the registered
// perf_overflow_irq output, which is the OR of the per-channel overflow flags.
// NUM_PERF_EVENTS must be at least 2 so that the select width is non-zero.

module perf_event_counter_bank #(
  parameter int NUM_PERF_EVENTS = 8,
  parameter int EVENT_IDX_WIDTH = $clog2(NUM_PERF_EVENTS),
  parameter int COUNTER_WIDTH   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PERF_EVENTS-1:0] perf_events,
  input  logic                       perf_freeze,
  input  logic [EVENT_IDX_WIDTH-1:0] cr_perf_event_select0,
  input  logic [EVENT_IDX_WIDTH-1:0] cr_perf_event_select1,
  output logic [63:0]                perf_event_count0,
  output logic [63:0]                perf_event_count1,
`ifdef PERF_OVERFLOW_IRQ_EN
  output logic                       perf_overflow_irq,
`endif
  output logic [1:0]                 perf_overflow
);

  // The sampled event vector is zero-padded to every encodable select value,
  // so an out-of-range select reads a constant zero and never counts.
  localparam int PADDED_EVENTS = 1 << EVENT_IDX_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  logic [NUM_PERF_EVENTS-1:0] event_q_r;
  logic [PADDED_EVENTS-1:0]   event_pad_s;

  logic [EVENT_IDX_WIDTH-1:0] sel_in_s  [2];
  logic [EVENT_IDX_WIDTH-1:0] sel_q_r   [2];
  logic [EVENT_IDX_WIDTH-1:0] sel_nxt_s [2];
  logic [COUNTER_WIDTH-1:0]   cnt_r     [2];
  logic [COUNTER_WIDTH-1:0]   cnt_nxt_s [2];
  logic [1:0]                 ovf_r;
  logic [1:0]                 ovf_nxt_s;

  assign sel_in_s[0]  = cr_perf_event_select0;
  assign sel_in_s[1]  = cr_perf_event_select1;
  assign event_pad_s  = PADDED_EVENTS'(event_q_r);

  // Per-channel next state: select change clears, else a selected event increments, else hold.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sel_nxt_s[i] = sel_q_r[i];
      cnt_nxt_s[i] = cnt_r[i];
      ovf_nxt_s[i] = ovf_r[i];
      if (sel_in_s[i] != sel_q_r[i]) begin
        // The event sampled this cycle belongs to the old selection and is dropped.
        sel_nxt_s[i] = sel_in_s[i];
        cnt_nxt_s[i] = '0;
        ovf_nxt_s[i] = 1'b0;
      end else if (event_pad_s[sel_q_r[i]]) begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
        if (&cnt_r[i]) begin
          ovf_nxt_s[i] = 1'b1;
        end else begin
          ovf_nxt_s[i] = ovf_r[i];
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Event sampling stage: freeze masks the incoming strobes, not the sampled ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      event_q_r <= '0;
    end else if (perf_freeze) begin
      event_q_r <= '0;
    end else begin
      event_q_r <= perf_events;
    end
  end

  // Counter, select and sticky overflow registers for both channels.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        sel_q_r[i] <= '0;
        cnt_r[i]   <= '0;
      end
      ovf_r <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sel_q_r[i] <= sel_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
      end
      ovf_r <= ovf_nxt_s;
    end
  end

`ifdef PERF_OVERFLOW_IRQ_EN
  // Interrupt flag registered from the next overflow state so it tracks perf_overflow cycle-for-cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_overflow_irq <= 1'b0;
    end else begin
      perf_overflow_irq <= |ovf_nxt_s;
    end
  end
`endif

  // Outputs come straight from flops; counters narrower than 64 bits are zero-extended.
  assign perf_event_count0 = 64'(cnt_r[0]);
  assign perf_event_count1 = 64'(cnt_r[1]);
  assign perf_overflow     = ovf_r;

endmodule
